// File: rtl/mac_tile_os_sys_if.sv
// Port bundle of one output-stationary MAC tile: systolic forwarding, drain chain and status.
// The slave modport is the tile's view; the master modport is the view of whatever drives it.
interface mac_tile_os_sys_if #(
    parameter int bw      = 4,
    parameter int psum_bw = 16
);
    logic [bw-1:0]      in_a;
    logic [bw-1:0]      in_w;
    logic [1:0]         inst_w;
    logic               is_signed;
    logic [psum_bw-1:0] in_s;
    logic               in_valid;
    logic [bw-1:0]      out_a;
    logic [bw-1:0]      out_w;
    logic [1:0]         inst_e;
    logic [psum_bw-1:0] out_s;
    logic               valid;
    logic               done;
    logic               sat_flag;
    logic               ovr_flag;

    modport slave (
        input  in_a, in_w, inst_w, is_signed, in_s, in_valid,
        output out_a, out_w, inst_e, out_s, valid, done, sat_flag, ovr_flag
    );

    modport master (
        output in_a, in_w, inst_w, is_signed, in_s, in_valid,
        input  out_a, out_w, inst_e, out_s, valid, done, sat_flag, ovr_flag
    );
endinterface

// File: rtl/mac_tile_os_sys.sv
// Output-stationary MAC tile: forwards activation/weight/instruction systolically, accumulates
// signed or unsigned products with optional saturation, and drains its psum north through a shift chain.
module mac_tile_os_sys #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int DEPTH   = 64,
    parameter int SAT     = 1
) (
    input  logic             clk,
    input  logic             reset,
    mac_tile_os_sys_if.slave t
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [psum_bw-1:0] S_MAX = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic [psum_bw-1:0] S_MIN = {1'b1, {(psum_bw-1){1'b0}}};
    localparam logic [psum_bw-1:0] U_MAX = {psum_bw{1'b1}};

    typedef enum logic [1:0] {IDLE, ACC, FULL, DRAIN} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      cnt, cnt_next, cnt_inc;
    logic [psum_bw-1:0] psum, psum_next;
    logic [psum_bw-1:0] out_s_q, out_s_next;
    logic               valid_q, valid_next;
    logic               sat_q, sat_next;
    logic               ovr_q, ovr_next;
    logic [bw-1:0]      a_q, w_q;
    logic [1:0]         inst_q;

    logic signed [2*bw-1:0]    prod_s;
    logic        [2*bw-1:0]    prod_u;
    logic        [psum_bw-1:0] prod_ext;
    logic        [psum_bw:0]   sum_w;
    logic        [psum_bw-1:0] mac_res;
    logic                      mac_ovf;
    logic                      mac_en;

    assign prod_s  = $signed(t.in_a) * $signed(t.in_w);
    assign prod_u  = t.in_a * t.in_w;
    assign cnt_inc = cnt + CW'(1);

    // Sum is one bit wider so overflow can be detected before the optional clamp.
    always_comb begin
        prod_ext = '0;
        sum_w    = '0;
        mac_res  = '0;
        mac_ovf  = 1'b0;
        if (t.is_signed) begin
            prod_ext = psum_bw'(prod_s);
            sum_w    = {psum[psum_bw-1], psum} + {prod_ext[psum_bw-1], prod_ext};
            mac_res  = sum_w[psum_bw-1:0];
            if ((SAT != 0) && (sum_w[psum_bw] != sum_w[psum_bw-1])) begin
                mac_ovf = 1'b1;
                mac_res = sum_w[psum_bw] ? S_MIN : S_MAX;
            end
        end else begin
            prod_ext = psum_bw'(prod_u);
            sum_w    = {1'b0, psum} + {1'b0, prod_ext};
            mac_res  = sum_w[psum_bw-1:0];
            if ((SAT != 0) && sum_w[psum_bw]) begin
                mac_ovf = 1'b1;
                mac_res = U_MAX;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state plus accumulator/counter/flag updates; clear overrides everything else.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        psum_next  = psum;
        sat_next   = sat_q;
        ovr_next   = ovr_q;
        mac_en     = 1'b0;
        out_s_next = out_s_q;
        valid_next = 1'b0;
        case (state)
            IDLE: begin
                if (t.inst_w == 2'b10) begin
                    mac_en     = 1'b1;
                    cnt_next   = CW'(1);
                    state_next = (DEPTH == 1) ? FULL : ACC;
                end else if (t.inst_w == 2'b11) begin
                    state_next = DRAIN;
                end
            end
            ACC: begin
                case (t.inst_w)
                    2'b10: begin
                        mac_en   = 1'b1;
                        cnt_next = cnt_inc;
                        if (cnt_inc == CW'(DEPTH)) state_next = FULL;
                    end
                    2'b01:   state_next = IDLE;
                    2'b11:   state_next = DRAIN;
                    default: state_next = ACC;
                endcase
            end
            FULL: begin
                case (t.inst_w)
                    2'b10:   ovr_next   = 1'b1;
                    2'b01:   state_next = IDLE;
                    2'b11:   state_next = DRAIN;
                    default: state_next = FULL;
                endcase
            end
            DRAIN: begin
                if (t.inst_w == 2'b01) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (mac_en) begin
            psum_next = mac_res;
            if (mac_ovf) sat_next = 1'b1;
        end

        if (t.inst_w == 2'b01) begin
            psum_next = '0;
            cnt_next  = '0;
            sat_next  = 1'b0;
            ovr_next  = 1'b0;
        end

        // First drain edge loads our own psum; later ones shift the southern neighbour up.
        if (state != DRAIN && state_next == DRAIN) begin
            out_s_next = psum;
            valid_next = 1'b1;
        end else if (state == DRAIN && state_next == DRAIN) begin
            out_s_next = t.in_s;
            valid_next = t.in_valid;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            psum    <= '0;
            out_s_q <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
            ovr_q   <= 1'b0;
            a_q     <= '0;
            w_q     <= '0;
            inst_q  <= '0;
        end else begin
            cnt     <= cnt_next;
            psum    <= psum_next;
            out_s_q <= out_s_next;
            valid_q <= valid_next;
            sat_q   <= sat_next;
            ovr_q   <= ovr_next;
            a_q     <= t.in_a;
            w_q     <= t.in_w;
            inst_q  <= t.inst_w;
        end
    end

    assign t.out_a    = a_q;
    assign t.out_w    = w_q;
    assign t.inst_e   = inst_q;
    assign t.out_s    = out_s_q;
    assign t.valid    = valid_q;
    assign t.done     = (state == FULL);
    assign t.sat_flag = sat_q;
    assign t.ovr_flag = ovr_q;
endmodule

// File: tb/tb_mac_tile_os_sys.sv
// Directed bench for mac_tile_os_sys: forwarding, unsigned/signed MAC, saturation, depth limit,
// and a three-tile drain column with an asynchronous reset in the middle of the drain.
module tb_mac_tile_os_sys;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mac_tile_os_sys_if #(.bw(4), .psum_bw(16)) m_if ();
    mac_tile_os_sys_if #(.bw(4), .psum_bw(8))  s_if ();
    mac_tile_os_sys_if #(.bw(4), .psum_bw(16)) d_if ();
    mac_tile_os_sys_if #(.bw(4), .psum_bw(16)) c0_if ();
    mac_tile_os_sys_if #(.bw(4), .psum_bw(16)) c1_if ();
    mac_tile_os_sys_if #(.bw(4), .psum_bw(16)) c2_if ();

    mac_tile_os_sys #(.bw(4), .psum_bw(16), .DEPTH(64), .SAT(1)) dut_main  (.clk(clk), .reset(reset), .t(m_if.slave));
    mac_tile_os_sys #(.bw(4), .psum_bw(8),  .DEPTH(64), .SAT(1)) dut_sat   (.clk(clk), .reset(reset), .t(s_if.slave));
    mac_tile_os_sys #(.bw(4), .psum_bw(16), .DEPTH(4),  .SAT(1)) dut_depth (.clk(clk), .reset(reset), .t(d_if.slave));
    mac_tile_os_sys #(.bw(4), .psum_bw(16), .DEPTH(64), .SAT(1)) dut_c0    (.clk(clk), .reset(reset), .t(c0_if.slave));
    mac_tile_os_sys #(.bw(4), .psum_bw(16), .DEPTH(64), .SAT(1)) dut_c1    (.clk(clk), .reset(reset), .t(c1_if.slave));
    mac_tile_os_sys #(.bw(4), .psum_bw(16), .DEPTH(64), .SAT(1)) dut_c2    (.clk(clk), .reset(reset), .t(c2_if.slave));

    // Drain chain: c0 is the top of the column, c2 the bottom.
    assign c0_if.in_s     = c1_if.out_s;
    assign c0_if.in_valid = c1_if.valid;
    assign c1_if.in_s     = c2_if.out_s;
    assign c1_if.in_valid = c2_if.valid;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus();
        m_if.in_a = '0;  m_if.in_w = '0;  m_if.inst_w = 2'b00;  m_if.is_signed = 1'b0;
        m_if.in_s = '0;  m_if.in_valid = 1'b0;
        s_if.in_a = '0;  s_if.in_w = '0;  s_if.inst_w = 2'b00;  s_if.is_signed = 1'b0;
        s_if.in_s = '0;  s_if.in_valid = 1'b0;
        d_if.in_a = '0;  d_if.in_w = '0;  d_if.inst_w = 2'b00;  d_if.is_signed = 1'b0;
        d_if.in_s = '0;  d_if.in_valid = 1'b0;
        c0_if.in_a = '0; c0_if.in_w = '0; c0_if.inst_w = 2'b00; c0_if.is_signed = 1'b0;
        c1_if.in_a = '0; c1_if.in_w = '0; c1_if.inst_w = 2'b00; c1_if.is_signed = 1'b0;
        c2_if.in_a = '0; c2_if.in_w = '0; c2_if.inst_w = 2'b00; c2_if.is_signed = 1'b0;
        c2_if.in_s = '0; c2_if.in_valid = 1'b0;
    endtask

    initial begin
        apply_stimulus();
        reset = 1'b1;
        #12;
        check_output("rst_out_a", 32'(m_if.out_a), 32'd0);
        check_output("rst_out_s", 32'(m_if.out_s), 32'd0);
        check_output("rst_valid", 32'(m_if.valid), 32'd0);
        check_output("rst_done", 32'(m_if.done), 32'd0);
        check_output("rst_flags", 32'({m_if.sat_flag, m_if.ovr_flag}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Forwarding
        m_if.in_a = 4'd5; m_if.in_w = 4'd3; m_if.inst_w = 2'b10;
        tick();
        check_output("fwd_out_a", 32'(m_if.out_a), 32'd5);
        check_output("fwd_out_w", 32'(m_if.out_w), 32'd3);
        check_output("fwd_inst_e", 32'(m_if.inst_e), 32'd2);
        m_if.inst_w = 2'b01;
        tick();
        check_output("clr_inst_e", 32'(m_if.inst_e), 32'd1);

        // Unsigned MAC: 3 x 15*15 = 675
        m_if.in_a = 4'd15; m_if.in_w = 4'd15; m_if.inst_w = 2'b10; m_if.is_signed = 1'b0;
        tick(); tick(); tick();
        m_if.inst_w = 2'b11;
        tick();
        check_output("u_out_s", 32'(m_if.out_s), 32'd675);
        check_output("u_valid", 32'(m_if.valid), 32'd1);
        tick();
        check_output("u_valid_drop", 32'(m_if.valid), 32'd0);
        m_if.inst_w = 2'b01;
        tick();

        // Signed MAC: -8*7 + 3*-2 = -62
        m_if.is_signed = 1'b1; m_if.inst_w = 2'b10;
        m_if.in_a = 4'h8; m_if.in_w = 4'd7;
        tick();
        m_if.in_a = 4'd3; m_if.in_w = 4'hE;
        tick();
        m_if.inst_w = 2'b11;
        tick();
        check_output("s_out_s", 32'(m_if.out_s), 32'h0000FFC2);
        check_output("s_valid", 32'(m_if.valid), 32'd1);
        check_output("s_no_sat", 32'(m_if.sat_flag), 32'd0);
        m_if.inst_w = 2'b01;
        tick();

        // Saturation on the 8-bit accumulator: 64 + 64 clamps to 127
        s_if.is_signed = 1'b1; s_if.in_a = 4'h8; s_if.in_w = 4'h8; s_if.inst_w = 2'b10;
        tick();
        check_output("sat_flag_first", 32'(s_if.sat_flag), 32'd0);
        tick();
        check_output("sat_flag_set", 32'(s_if.sat_flag), 32'd1);
        s_if.inst_w = 2'b11;
        tick();
        check_output("sat_out_s", 32'(s_if.out_s), 32'd127);
        s_if.inst_w = 2'b01;
        tick();
        check_output("sat_flag_clr", 32'(s_if.sat_flag), 32'd0);
        s_if.inst_w = 2'b11;
        tick();
        check_output("sat_psum_clr", 32'(s_if.out_s), 32'd0);
        check_output("sat_clr_valid", 32'(s_if.valid), 32'd1);
        s_if.inst_w = 2'b00;

        // Depth limit of 4: done after the 4th MAC, later MACs dropped and flagged
        d_if.in_a = 4'd1; d_if.in_w = 4'd1; d_if.inst_w = 2'b10;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check_output($sformatf("depth_done_%0d", i), 32'(d_if.done), (i >= 4) ? 32'd1 : 32'd0);
            check_output($sformatf("depth_ovr_%0d", i), 32'(d_if.ovr_flag), (i >= 5) ? 32'd1 : 32'd0);
        end
        d_if.inst_w = 2'b11;
        tick();
        check_output("depth_out_s", 32'(d_if.out_s), 32'd4);
        check_output("depth_done_drain", 32'(d_if.done), 32'd0);
        d_if.inst_w = 2'b00;

        // Column of three: load 7, 8, 9 then drain top-first
        c0_if.in_a = 4'd7; c1_if.in_a = 4'd8; c2_if.in_a = 4'd9;
        c0_if.in_w = 4'd1; c1_if.in_w = 4'd1; c2_if.in_w = 4'd1;
        c0_if.inst_w = 2'b10; c1_if.inst_w = 2'b10; c2_if.inst_w = 2'b10;
        tick();
        c0_if.inst_w = 2'b11; c1_if.inst_w = 2'b11; c2_if.inst_w = 2'b11;
        tick();
        check_output("chain_0", 32'(c0_if.out_s), 32'd7);
        check_output("chain_0_v", 32'(c0_if.valid), 32'd1);
        tick();
        check_output("chain_1", 32'(c0_if.out_s), 32'd8);
        check_output("chain_1_v", 32'(c0_if.valid), 32'd1);
        tick();
        check_output("chain_2", 32'(c0_if.out_s), 32'd9);
        check_output("chain_2_v", 32'(c0_if.valid), 32'd1);
        tick();
        check_output("chain_end_v", 32'(c0_if.valid), 32'd0);

        // Reload and abort the drain with an asynchronous reset
        c0_if.inst_w = 2'b01; c1_if.inst_w = 2'b01; c2_if.inst_w = 2'b01;
        tick();
        c0_if.inst_w = 2'b10; c1_if.inst_w = 2'b10; c2_if.inst_w = 2'b10;
        tick();
        c0_if.inst_w = 2'b11; c1_if.inst_w = 2'b11; c2_if.inst_w = 2'b11;
        tick();
        check_output("rechain_0", 32'(c0_if.out_s), 32'd7);
        #2;
        reset = 1'b1;
        #1;
        check_output("abort_c0_s", 32'(c0_if.out_s), 32'd0);
        check_output("abort_c0_v", 32'(c0_if.valid), 32'd0);
        check_output("abort_c1_s", 32'(c1_if.out_s), 32'd0);
        check_output("abort_c2_s", 32'(c2_if.out_s), 32'd0);
        check_output("abort_c0_a", 32'(c0_if.out_a), 32'd0);
        tick();
        check_output("abort_hold_v", 32'(c0_if.valid), 32'd0);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
